regfile_mp: RTL and testbench

Parametrised multi-port register file for the RISC-V core, the successor to the single-write, dual-read register file. It adds configurable width, depth, and read/write port counts, plus a per-register busy scoreboard for the out-of-order writeback path. A hardware clear sequencer zeroes every entry after reset, so no simulation-only initialisation is needed. It sits between decode (reads and claims) and the writeback stage (writes).

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_mp.sv | 133 +++++++++++++
 tb/tb_regfile_mp.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: sequencer states,
// default geometry and the architectural register index type.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_IW    = $clog2(RF_DEPTH);

    typedef logic [RF_IW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-side bundle of the register file: write ports, claim port,
// read ports and the ready indication.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) ();
    localparam int IW = $clog2(DEPTH);

    logic                               ready;
    logic [NUM_WR-1:0]                  wr_en;
    logic [NUM_WR-1:0][IW-1:0]          wr_idx;
    logic [NUM_WR-1:0][WIDTH-1:0]       wr_data;
    logic                               claim_en;
    logic [IW-1:0]                      claim_idx;
    logic [NUM_RD-1:0][IW-1:0]          rd_idx;
    logic [NUM_RD-1:0][WIDTH-1:0]       rd_data;
    logic [NUM_RD-1:0]                  rd_busy;

    modport master (
        input  ready, rd_data, rd_busy,
        output wr_en, wr_idx, wr_data, claim_en, claim_idx, rd_idx
    );

    modport slave (
        output ready, rd_data, rd_busy,
        input  wr_en, wr_idx, wr_data, claim_en, claim_idx, rd_idx
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: writes release a register, claims mark it busy (claim
// wins over a same-cycle write), and the clear sequencer zeroes one bit per cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter int IW       = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_en,
    input  logic [IW-1:0]             clr_idx,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR-1:0][IW-1:0] wr_idx,
    input  logic                      claim_en,
    input  logic [IW-1:0]             claim_idx,
    output logic [DEPTH-1:0]          busy
);

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;
    logic             claim_eff_s;

    // Next busy vector: clear step, then write releases, then the claim on top
    always_comb begin
        busy_nxt_s  = busy_r;
        claim_eff_s = claim_en && !(ZERO_REG && (claim_idx == '0));
        if (clr_en) begin
            busy_nxt_s[clr_idx] = 1'b0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                busy_nxt_s[wr_idx[i]] = wr_en[i] ? 1'b0 : busy_nxt_s[wr_idx[i]];
            end
            busy_nxt_s[claim_idx] = claim_eff_s ? 1'b1 : busy_nxt_s[claim_idx];
        end
        busy_nxt_s[0] = ZERO_REG ? 1'b0 : busy_nxt_s[0];
    end

    // Busy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write bypass, busy scoreboard and
// a post-reset clear sequencer that zeroes every entry before ready rises.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    localparam int          IW       = $clog2(DEPTH);
    localparam logic [IW:0] CNT_LAST = (IW+1)'(DEPTH - 1);
    localparam logic [IW:0] CNT_ONE  = (IW+1)'(1);

    rf_state_e                    state_r;
    logic [IW:0]                  cnt_r;
    logic                         ready_r;
    (* ramstyle = "logic" *) logic [WIDTH-1:0] mem_r [DEPTH];

    logic                         clr_en_s;
    logic [IW-1:0]                clr_idx_s;
    logic [NUM_WR-1:0]            wr_eff_s;
    logic                         claim_eff_s;
    logic [DEPTH-1:0]             busy_s;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data_s;
    logic [NUM_RD-1:0]            rd_busy_s;

    // Clear sequencer: walks cnt over every index, then holds in READY
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= CLEAR;
            cnt_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= READY;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= CLEAR;
                        ready_r <= 1'b0;
                    end
                end
                READY: begin
                    state_r <= READY;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= CLEAR;
                    cnt_r   <= '0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en_s    = (state_r == CLEAR) && !rst;
    assign clr_idx_s   = cnt_r[IW-1:0];
    assign claim_eff_s = ready_r && bus.claim_en;

    // Effective write enables: only in READY, and never to the hardwired zero
    always_comb begin
        wr_eff_s = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wr_eff_s[i] = ready_r && bus.wr_en[i] && !(ZERO_REG && (bus.wr_idx[i] == '0));
        end
    end

    // Storage: clear step during CLEAR, otherwise writes with later ports winning
    always_ff @(posedge clk) begin
        if (clr_en_s) begin
            mem_r[clr_idx_s] <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_eff_s[i]) begin
                    mem_r[bus.wr_idx[i]] <= bus.wr_data[i];
                end
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .IW       (IW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .clr_en    (clr_en_s),
        .clr_idx   (clr_idx_s),
        .wr_en     (wr_eff_s),
        .wr_idx    (bus.wr_idx),
        .claim_en  (claim_eff_s),
        .claim_idx (bus.claim_idx),
        .busy      (busy_s)
    );

    // Read ports: stored value, overridden by the highest matching write port
    always_comb begin : rd_mux
        logic hit_v;
        logic gate_v;
        hit_v     = 1'b0;
        gate_v    = 1'b0;
        rd_data_s = '0;
        rd_busy_s = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rd_data_s[j] = mem_r[bus.rd_idx[j]];
            rd_busy_s[j] = busy_s[bus.rd_idx[j]];
            for (int i = 0; i < NUM_WR; i++) begin
                hit_v        = wr_eff_s[i] && (bus.wr_idx[i] == bus.rd_idx[j]);
                rd_data_s[j] = hit_v ? bus.wr_data[i] : rd_data_s[j];
                rd_busy_s[j] = hit_v ? 1'b0 : rd_busy_s[j];
            end
            gate_v       = ready_r && !(ZERO_REG && (bus.rd_idx[j] == '0));
            rd_data_s[j] = gate_v ? rd_data_s[j] : '0;
            rd_busy_s[j] = gate_v && rd_busy_s[j];
        end
    end

    assign bus.ready   = ready_r;
    assign bus.rd_data = rd_data_s;
    assign bus.rd_busy = rd_busy_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: clear sequence, table vectors for the directed cases,
// randomized traffic against an array model, and reset during operation.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW)) rf_if ();

    regfile_mp #(
        .WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m  [D];
    bit          busy_m [D];
    bit          model_on;

    typedef struct {
        logic [1:0]  we;
        int          wi0, wi1;
        logic [31:0] wd0, wd1;
        logic        ce;
        int          ci;
        int          r0, r1;
        logic [31:0] ed0;
        logic        eb0;
        logic [31:0] ed1;
        logic        eb1;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] we, input int wi0, input int wi1,
                          input logic [31:0] wd0, input logic [31:0] wd1,
                          input logic ce, input int ci, input int r0, input int r1);
        rf_if.wr_en      = we;
        rf_if.wr_idx[0]  = reg_idx_t'(wi0);
        rf_if.wr_idx[1]  = reg_idx_t'(wi1);
        rf_if.wr_data[0] = wd0;
        rf_if.wr_data[1] = wd1;
        rf_if.claim_en   = ce;
        rf_if.claim_idx  = reg_idx_t'(ci);
        rf_if.rd_idx[0]  = reg_idx_t'(r0);
        rf_if.rd_idx[1]  = reg_idx_t'(r1);
    endtask

    task automatic set_idle(input int r0, input int r1);
        set_in(2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0, r0, r1);
    endtask

    task automatic model_clear();
        for (int r = 0; r < D; r++) begin
            mem_m[r]  = 32'h0;
            busy_m[r] = 1'b0;
        end
    endtask

    // Expected read: zero register and not-ready read as zero; the latest-numbered
    // matching write port is forwarded; otherwise the model array.
    task automatic model_read(input int idx, output logic [31:0] d, output logic b);
        d = 32'h0;
        b = 1'b0;
        if (model_on && idx != 0) begin
            d = mem_m[idx];
            b = busy_m[idx];
            for (int i = NW - 1; i >= 0; i--) begin
                if (rf_if.wr_en[i] && int'(rf_if.wr_idx[i]) == idx) begin
                    d = rf_if.wr_data[i];
                    b = 1'b0;
                    break;
                end
            end
        end
    endtask

    // Advance one clock, applying the current inputs to the model first
    task automatic cycle();
        if (model_on && !rst) begin
            for (int i = 0; i < NW; i++) begin
                if (rf_if.wr_en[i] && rf_if.wr_idx[i] != 0) begin
                    mem_m[rf_if.wr_idx[i]]  = rf_if.wr_data[i];
                    busy_m[rf_if.wr_idx[i]] = 1'b0;
                end
            end
            if (rf_if.claim_en && rf_if.claim_idx != 0) begin
                busy_m[rf_if.claim_idx] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        for (int e = 1; e <= 40; e++) begin
            cycle();
            if (rf_if.ready === 1'b1) begin
                k = e;
                break;
            end
        end
    endtask

    initial begin
        int          rise;
        logic [31:0] ed;
        logic        eb;

        tbl[0]  = '{2'b01, 5, 0, 32'hDEADBEEF, 32'h0, 1'b0, 0, 5, 6, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{2'b00, 5, 0, 32'hDEADBEEF, 32'h0, 1'b0, 0, 5, 7, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
        tbl[2]  = '{2'b11, 7, 7, 32'h1111, 32'h2222, 1'b0, 0, 7, 5, 32'h2222, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[3]  = '{2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0, 7, 7, 32'h2222, 1'b0, 32'h2222, 1'b0};
        tbl[4]  = '{2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 9, 9, 7, 32'h0, 1'b0, 32'h2222, 1'b0};
        tbl[5]  = '{2'b00, 9, 9, 32'hBAD, 32'hBAD, 1'b0, 0, 9, 9, 32'h0, 1'b1, 32'h0, 1'b1};
        tbl[6]  = '{2'b10, 0, 9, 32'h0, 32'h55, 1'b0, 0, 9, 5, 32'h55, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[7]  = '{2'b01, 9, 0, 32'h55, 32'h0, 1'b1, 9, 9, 9, 32'h55, 1'b0, 32'h55, 1'b0};
        tbl[8]  = '{2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0, 9, 5, 32'h55, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[9]  = '{2'b01, 0, 0, 32'hFFFFFFFF, 32'h0, 1'b1, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[10] = '{2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0, 0, 9, 32'h0, 1'b0, 32'h55, 1'b1};
        tbl[11] = '{2'b11, 12, 9, 32'h88, 32'h77, 1'b0, 0, 9, 12, 32'h77, 1'b0, 32'h88, 1'b0};
        tbl[12] = '{2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0, 9, 12, 32'h77, 1'b0, 32'h88, 1'b0};
        tbl[13] = '{2'b11, 3, 0, 32'h3, 32'hFFFFFFFF, 1'b0, 0, 0, 3, 32'h0, 1'b0, 32'h3, 1'b0};

        // Reset and first clear sequence; writes and claims offered during clear
        model_on = 1'b0;
        model_clear();
        rst = 1'b1;
        set_idle(0, 0);
        @(posedge clk);
        #1;
        check("reset_ready", {31'b0, rf_if.ready}, 32'h0);
        rst = 1'b0;
        set_in(2'b11, 5, 6, 32'h12345678, 32'h9, 1'b1, 5, 5, 6);
        #1;
        check("clear_rd_data0", rf_if.rd_data[0], 32'h0);
        check("clear_rd_busy0", {31'b0, rf_if.rd_busy[0]}, 32'h0);
        check("clear_rd_data1", rf_if.rd_data[1], 32'h0);
        wait_ready(rise);
        check("clear_latency", rise, 32);
        set_idle(0, 0);
        model_on = 1'b1;
        for (int r = 0; r < D; r += 2) begin
            set_idle(r, r + 1);
            #1;
            check($sformatf("cleared_x%0d", r), rf_if.rd_data[0], 32'h0);
            check($sformatf("cleared_x%0d", r + 1), rf_if.rd_data[1], 32'h0);
            check($sformatf("cleared_busy_x%0d", r), {30'b0, rf_if.rd_busy}, 32'h0);
        end

        // Directed table: bypass, conflict, scoreboard and zero-register rows
        for (int v = 0; v < 14; v++) begin
            set_in(tbl[v].we, tbl[v].wi0, tbl[v].wi1, tbl[v].wd0, tbl[v].wd1,
                   tbl[v].ce, tbl[v].ci, tbl[v].r0, tbl[v].r1);
            #2;
            check($sformatf("vec%0d_d0", v), rf_if.rd_data[0], tbl[v].ed0);
            check($sformatf("vec%0d_b0", v), {31'b0, rf_if.rd_busy[0]}, {31'b0, tbl[v].eb0});
            check($sformatf("vec%0d_d1", v), rf_if.rd_data[1], tbl[v].ed1);
            check($sformatf("vec%0d_b1", v), {31'b0, rf_if.rd_busy[1]}, {31'b0, tbl[v].eb1});
            cycle();
        end

        // Randomized traffic against the array model
        for (int n = 0; n < 400; n++) begin
            int lim, wi0, wi1, r0, r1;
            lim = ($urandom_range(0, 3) == 0) ? 31 : 7;
            wi0 = $urandom_range(0, lim);
            wi1 = $urandom_range(0, lim);
            r0  = $urandom_range(0, 1) ? wi0 : $urandom_range(0, lim);
            r1  = $urandom_range(0, 1) ? wi1 : $urandom_range(0, lim);
            set_in(2'($urandom_range(0, 3)), wi0, wi1, $urandom(), $urandom(),
                   ($urandom_range(0, 2) == 0), $urandom_range(0, lim), r0, r1);
            #2;
            for (int j = 0; j < NR; j++) begin
                model_read(int'(rf_if.rd_idx[j]), ed, eb);
                check($sformatf("rand%0d_d%0d", n, j), rf_if.rd_data[j], ed);
                check($sformatf("rand%0d_b%0d", n, j), {31'b0, rf_if.rd_busy[j]}, {31'b0, eb});
            end
            cycle();
        end

        // Reset in READY, then reset again partway through the clear
        set_in(2'b10, 0, 3, 32'h0, 32'hABC, 1'b1, 3, 3, 3);
        cycle();
        set_idle(3, 3);
        #1;
        check("x3_loaded", rf_if.rd_data[0], 32'hABC);
        check("x3_busy", {31'b0, rf_if.rd_busy[0]}, 32'h1);
        model_on = 1'b0;
        model_clear();
        rst = 1'b1;
        cycle();
        check("rst_ready_fall", {31'b0, rf_if.ready}, 32'h0);
        rst = 1'b0;
        #1;
        check("midclear_x3", rf_if.rd_data[0], 32'h0);
        for (int e = 0; e < 10; e++) begin
            cycle();
        end
        check("ready_low_at_10", {31'b0, rf_if.ready}, 32'h0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wait_ready(rise);
        check("restart_latency", rise, 32);
        model_on = 1'b1;
        set_idle(3, 9);
        #1;
        check("x3_after_clear", rf_if.rd_data[0], 32'h0);
        check("x3_busy_after_clear", {31'b0, rf_if.rd_busy[0]}, 32'h0);
        check("x9_after_clear", rf_if.rd_data[1], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
